// File: rtl/alu_ex_stage.sv
// alu_ex_stage: MIPS execute stage. Selects operands through the forwarding
// and immediate muxes, performs the ALU operation, and captures the result
// together with the pass-through control into the EX/MEM pipeline register.
// All outputs come directly from registers (one cycle latency).
module alu_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_W-1:0]  rd_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              mem_to_reg_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] fwd_rt_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] result_s;
  logic              zero_s;
  logic              reg_write_s;
  logic              mem_read_s;
  logic              mem_write_s;
  logic              mem_to_reg_s;

  logic              valid_r;
  logic [DATA_W-1:0] result_r;
  logic              zero_r;
  logic [DATA_W-1:0] store_r;
  logic [REG_W-1:0]  rd_r;
  logic              reg_write_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic              mem_to_reg_r;

  // Operand selection: forwarding muxes for A and rt, then the immediate mux for B.
  always_comb begin
    op_a_s   = rs_data;
    fwd_rt_s = rt_data;
    case (fwd_a)
      2'b10:   op_a_s = mem_fwd_data;
      2'b01:   op_a_s = wb_fwd_data;
      default: op_a_s = rs_data;  // 00 and the reserved 11 both take rs
    endcase
    case (fwd_b)
      2'b10:   fwd_rt_s = mem_fwd_data;
      2'b01:   fwd_rt_s = wb_fwd_data;
      default: fwd_rt_s = rt_data;
    endcase
    if (alu_src) begin
      op_b_s = imm;
    end else begin
      op_b_s = fwd_rt_s;
    end
  end

  // ALU operation; add/sub wrap silently, unknown codes yield 0.
  always_comb begin
    result_s = ZERO_W;
    case (alu_ctrl)
      OP_ADD:  result_s = op_a_s + op_b_s;
      OP_SUB:  result_s = op_a_s - op_b_s;
      OP_AND:  result_s = op_a_s & op_b_s;
      OP_OR:   result_s = op_a_s | op_b_s;
      OP_SLT:  result_s = ($signed(op_a_s) < $signed(op_b_s)) ? ONE_W : ZERO_W;
      OP_NOR:  result_s = ~(op_a_s | op_b_s);
      default: result_s = ZERO_W;
    endcase
    zero_s = (result_s == ZERO_W);
  end

  // Control bits of a non-valid slot are squashed so a bubble cannot write state.
  always_comb begin
    reg_write_s  = valid_in & reg_write_in;
    mem_read_s   = valid_in & mem_read_in;
    mem_write_s  = valid_in & mem_write_in;
    mem_to_reg_s = valid_in & mem_to_reg_in;
  end

  // EX/MEM register: reset and flush clear everything, stall holds, else load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r      <= 1'b0;
      result_r     <= ZERO_W;
      zero_r       <= 1'b0;
      store_r      <= ZERO_W;
      rd_r         <= {REG_W{1'b0}};
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
    end else if (stall) begin
      valid_r      <= valid_r;
      result_r     <= result_r;
      zero_r       <= zero_r;
      store_r      <= store_r;
      rd_r         <= rd_r;
      reg_write_r  <= reg_write_r;
      mem_read_r   <= mem_read_r;
      mem_write_r  <= mem_write_r;
      mem_to_reg_r <= mem_to_reg_r;
    end else begin
      valid_r      <= valid_in;
      result_r     <= result_s;
      zero_r       <= zero_s;
      store_r      <= fwd_rt_s;
      rd_r         <= rd_in;
      reg_write_r  <= reg_write_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      mem_to_reg_r <= mem_to_reg_s;
    end
  end

  assign valid_out      = valid_r;
  assign alu_result     = result_r;
  assign zero           = zero_r;
  assign store_data     = store_r;
  assign rd_out         = rd_r;
  assign reg_write_out  = reg_write_r;
  assign mem_read_out   = mem_read_r;
  assign mem_write_out  = mem_write_r;
  assign mem_to_reg_out = mem_to_reg_r;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed self-checking bench for the EX stage.
module tb_alu_ex_stage;

  logic        clk;
  logic        rst, stall, flush, valid_in;
  logic [3:0]  alu_ctrl;
  logic [31:0] rs_data, rt_data, imm, mem_fwd_data, wb_fwd_data;
  logic        alu_src;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        valid_out, zero;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;

  int tests_run = 0;
  int tests_failed = 0;

  alu_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_ctrl(alu_ctrl), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .valid_out(valid_out), .alu_result(alu_result), .zero(zero),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, valid_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out},
          {27'd0, exp});
  endtask

  task automatic base(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
    alu_ctrl = op; rs_data = a; rt_data = b; imm = 32'h0000_0000;
    alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    mem_fwd_data = 32'hDEAD_0000; wb_fwd_data = 32'hBEEF_0000;
    rd_in = 5'd7; reg_write_in = 1'b1; mem_read_in = 1'b0;
    mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b1; stall = $urandom_range(0, 1); flush = 1'b0; valid_in = 1'b1;
    alu_ctrl = 4'b0010; rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    alu_src = $urandom_range(0, 1); fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
    mem_fwd_data = $urandom; wb_fwd_data = $urandom; rd_in = 5'($urandom_range(0, 31));
    reg_write_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1; mem_to_reg_in = 1'b1;
    tick(); tick();
    check("rst_result", alu_result, 32'h0);
    check("rst_store", store_data, 32'h0);
    check("rst_rd", {27'd0, rd_out}, 32'h0);
    check("rst_zero", {31'd0, zero}, 32'h0);
    check_ctrl("rst_ctrl", 5'b00000);
    rst = 1'b0;

    // ALU operations, A=5, B=3
    base(4'b0010, 32'h5, 32'h3); tick();
    check("add", alu_result, 32'h8);
    check("add_zero", {31'd0, zero}, 32'h0);
    check("add_store", store_data, 32'h3);
    check("add_rd", {27'd0, rd_out}, 32'd7);
    check_ctrl("add_ctrl", 5'b11000);
    base(4'b0110, 32'h5, 32'h3); tick(); check("sub", alu_result, 32'h2);
    base(4'b0000, 32'h5, 32'h3); tick(); check("and", alu_result, 32'h1);
    base(4'b0001, 32'h5, 32'h3); tick(); check("or", alu_result, 32'h7);
    base(4'b1100, 32'h5, 32'h3); tick(); check("nor", alu_result, 32'hFFFF_FFF8);
    base(4'b1111, 32'h5, 32'h3); tick();
    check("bad_op", alu_result, 32'h0);
    check("bad_op_zero", {31'd0, zero}, 32'h1);

    // arithmetic edges
    base(4'b0010, 32'hFFFF_FFFF, 32'h1); tick();
    check("add_wrap", alu_result, 32'h0);
    check("add_wrap_zero", {31'd0, zero}, 32'h1);
    base(4'b0110, 32'h0, 32'h1); tick(); check("sub_wrap", alu_result, 32'hFFFF_FFFF);
    base(4'b0111, 32'h8000_0000, 32'h1); tick(); check("slt_neg", alu_result, 32'h1);
    base(4'b0111, 32'h1, 32'h8000_0000); tick(); check("slt_pos", alu_result, 32'h0);

    // forwarding
    base(4'b0010, 32'h1, 32'h2); mem_fwd_data = 32'h10; wb_fwd_data = 32'h20;
    fwd_a = 2'b10; tick(); check("fwd_a_mem", alu_result, 32'h12);
    fwd_a = 2'b01; tick(); check("fwd_a_wb", alu_result, 32'h22);
    fwd_a = 2'b11; tick(); check("fwd_a_rsv", alu_result, 32'h3);
    fwd_a = 2'b00; fwd_b = 2'b01; tick();
    check("fwd_b_wb", alu_result, 32'h21);
    check("fwd_b_wb_store", store_data, 32'h20);
    fwd_b = 2'b10; alu_src = 1'b1; imm = 32'h4; tick();
    check("fwd_b_imm", alu_result, 32'h5);
    check("fwd_b_imm_store", store_data, 32'h10);

    // stall holds for three cycles while inputs change
    base(4'b0010, 32'h5, 32'h3); mem_read_in = 1'b1; tick();
    check("pre_stall", alu_result, 32'h8);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; valid_in = 1'b0; alu_ctrl = 4'b0110;
      rs_data = $urandom; rt_data = $urandom; rd_in = 5'd3;
      fwd_a = 2'b10; fwd_b = 2'b01; mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      tick();
      check("stall_result", alu_result, 32'h8);
      check("stall_store", store_data, 32'h3);
      check("stall_rd", {27'd0, rd_out}, 32'd7);
      check_ctrl("stall_ctrl", 5'b11100);
    end

    // flush beats stall
    stall = 1'b1; flush = 1'b1; valid_in = 1'b1; tick();
    check_ctrl("flush_ctrl", 5'b00000);
    check("flush_result", alu_result, 32'h0);
    check("flush_zero", {31'd0, zero}, 32'h0);

    // bubble: valid_in=0 squashes control, data still loads
    base(4'b0010, 32'h5, 32'h3); valid_in = 1'b0;
    mem_write_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1; tick();
    check_ctrl("bubble_ctrl", 5'b00000);
    check("bubble_result", alu_result, 32'h8);

    // reset during a stall drops the held instruction
    base(4'b0001, 32'h5, 32'h3); tick();
    check_ctrl("pre_rst_ctrl", 5'b11000);
    stall = 1'b1; rst = 1'b1; tick();
    check("rst_stall_result", alu_result, 32'h0);
    check_ctrl("rst_stall_ctrl", 5'b00000);
    rst = 1'b0; stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code, selects operands through forwarding and immediate muxes, and performs the ALU operation.
- Registers the result and the pass-through control into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM contents
- flush  in  1  load a bubble into EX/MEM
- valid_in  in  1  ID/EX holds a real instruction
- alu_ctrl  in  4  ALU operation code from ALU control
- rs_data  in  DATA_W  ID/EX rs value
- rt_data  in  DATA_W  ID/EX rt value
- imm  in  DATA_W  sign-extended immediate
- alu_src  in  1  1: operand B = imm
- fwd_a  in  2  operand A forward select
- fwd_b  in  2  operand B forward select
- mem_fwd_data  in  DATA_W  EX/MEM ALU result, for forwarding
- wb_fwd_data  in  DATA_W  MEM/WB writeback value, for forwarding
- rd_in  in  REG_W  destination register
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  control pass-through
- valid_out  out  1  EX/MEM holds a real instruction
- alu_result  out  DATA_W  registered ALU result
- zero  out  1  registered (result == 0)
- store_data  out  DATA_W  registered forwarded rt value, for sw
- rd_out  out  REG_W  registered destination register
- reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out  out  1 each  registered control

Behaviour:
- Latency: 1 cycle. Combinational EX logic is captured into EX/MEM at the rising edge; all outputs come directly from registers.
- Forward mux A (fwd_a):
  - 00 -> rs_data
  - 10 -> mem_fwd_data
  - 01 -> wb_fwd_data
  - 11 -> rs_data (reserved)
- Forward mux B (fwd_b): same encoding applied to rt_data, giving fwd_rt.
- Operand B = alu_src ? imm : fwd_rt.
- store_data captures fwd_rt, never imm.
- ALU operations on alu_ctrl:
  - 0010 add
  - 0110 sub
  - 0000 and
  - 0001 or
  - 0111 slt: signed compare; result 32'h1 if A < B, else 0
  - 1100 nor
  - any other code: result 0
- Add and sub wrap modulo 2^DATA_W. No overflow detection and no trap.
- zero is computed on the combinational result and captured alongside it.
- Register update priority, highest first: rst > flush > stall > normal load.
  - rst: every output register is cleared to 0, including valid_out, all control bits, alu_result, store_data and rd_out. zero resets to 0, not 1.
  - flush: same clear as rst; this inserts a bubble. Flush and stall together: flush wins.
  - stall (no flush): all EX/MEM registers hold their values, and forwarding inputs are ignored that cycle.
  - normal: all registers load. When valid_in = 0, the four control bits are forced to 0 and valid_out is 0; the data fields still load.
- rst asserted mid-stream, including during a stall: outputs are 0 on the next edge, and the held instruction is lost.
- No internal state beyond EX/MEM.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, zero=0, valid_out=0.
- ALU ops, fwd=00, alu_src=0:
  - A=0x00000005, B=0x00000003, ctrl 0010 -> alu_result=0x8 one cycle later.
  - ctrl 0110 -> 0x2.
  - ctrl 0000 -> 0x1.
  - ctrl 0001 -> 0x7.
  - ctrl 1100 -> 0xFFFFFFF8.
  - ctrl 1111 -> 0x0 with zero=1.
- Arithmetic edges:
  - A=0xFFFFFFFF + B=1 -> 0x0, zero=1.
  - slt with A=0x80000000, B=1 -> 0x1.
  - slt with A=1, B=0x80000000 -> 0x0.
- Forwarding:
  - rs_data=1, mem_fwd_data=0x10, wb_fwd_data=0x20, rt_data=2, add.
  - fwd_a=10 -> 0x12; fwd_a=01 -> 0x22.
  - fwd_b=10 with alu_src=1, imm=4, fwd_a=00 -> result 0x5, store_data=0x10.
- Stall/flush:
  - Load add result 0x8, then stall=1 for 3 cycles with changing inputs -> outputs stay 0x8 and valid_out=1.
  - stall=1 and flush=1 together -> valid_out=0 and all control bits 0 next cycle.
- Bubble: valid_in=0 with reg_write_in=1, mem_write_in=1 -> reg_write_out=0, mem_write_out=0, valid_out=0.
